// File: rtl/serial_add_seq.sv
// rtl/serial_add_seq.sv - bit-serial two-operand adder sequencer around one full-adder slice
// Optional signed-overflow output enabled by defining SERIAL_ADD_OVF_EN.
module serial_add_seq #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a_in,
    input  logic [WIDTH-1:0] b_in,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
`ifdef SERIAL_ADD_OVF_EN
    output logic             cout,
    output logic             ovf
`else
    output logic             cout
`endif
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_sr_q, a_sr_d;
    logic [WIDTH-1:0] b_sr_q, b_sr_d;
    logic [WIDTH-1:0] res_q, res_d;
    logic             carry_q, carry_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             fa_s, fa_co;
`ifdef SERIAL_ADD_OVF_EN
    logic             ovf_q, ovf_d;
`endif

    // The single adder slice: always fed from the shift-register LSBs and the carry flop.
    always_comb begin
        fa_s  = a_sr_q[0] ^ b_sr_q[0] ^ carry_q;
        fa_co = (a_sr_q[0] & b_sr_q[0]) | (a_sr_q[0] & carry_q) | (b_sr_q[0] & carry_q);
    end

    always_comb begin
        state_d = state_q;
        a_sr_d  = a_sr_q;
        b_sr_d  = b_sr_q;
        res_d   = res_q;
        carry_d = carry_q;
        cnt_d   = cnt_q;
`ifdef SERIAL_ADD_OVF_EN
        ovf_d   = ovf_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_SHIFT;
                    a_sr_d  = a_in;
                    b_sr_d  = b_in;
                    carry_d = cin;
                    res_d   = '0;
                    cnt_d   = '0;
`ifdef SERIAL_ADD_OVF_EN
                    ovf_d   = 1'b0;
`endif
                end
            end
            S_SHIFT: begin
                a_sr_d  = {1'b0, a_sr_q[WIDTH-1:1]};
                b_sr_d  = {1'b0, b_sr_q[WIDTH-1:1]};
                // Sum bits enter at the top so the LSB lands at bit 0 after WIDTH shifts.
                res_d   = {fa_s, res_q[WIDTH-1:1]};
                carry_d = fa_co;
                cnt_d   = cnt_q + CW'(1);
                if (cnt_q == CNT_LAST) begin
                    state_d = S_DONE;
`ifdef SERIAL_ADD_OVF_EN
                    ovf_d   = carry_q ^ fa_co;
`endif
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            a_sr_q  <= '0;
            b_sr_q  <= '0;
            res_q   <= '0;
            carry_q <= 1'b0;
            cnt_q   <= '0;
`ifdef SERIAL_ADD_OVF_EN
            ovf_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            a_sr_q  <= a_sr_d;
            b_sr_q  <= b_sr_d;
            res_q   <= res_d;
            carry_q <= carry_d;
            cnt_q   <= cnt_d;
`ifdef SERIAL_ADD_OVF_EN
            ovf_q   <= ovf_d;
`endif
        end
    end

    assign busy = (state_q != S_IDLE);
    assign done = (state_q == S_DONE);
    assign sum  = res_q;
    assign cout = carry_q;
`ifdef SERIAL_ADD_OVF_EN
    assign ovf  = ovf_q;
`endif

endmodule

// File: tb/tb_serial_add_seq.sv
// tb/tb_serial_add_seq.sv - self-checking bench for serial_add_seq at WIDTH=8 and WIDTH=32
module tb_serial_add_seq;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [31:0] a_in, b_in;
    logic        cin;
    int          sel_r;

    logic        busy8, done8, cout8, ovf8;
    logic [7:0]  sum8;
    logic        busy32, done32, cout32, ovf32;
    logic [31:0] sum32;

    logic        busy_o, done_o, cout_o, ovf_o;
    logic [31:0] sum_o;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    serial_add_seq #(.WIDTH(8)) dut8 (
        .clk(clk), .rst(rst), .start(start & (sel_r == 0)),
        .a_in(a_in[7:0]), .b_in(b_in[7:0]), .cin(cin),
        .busy(busy8), .done(done8), .sum(sum8),
`ifdef SERIAL_ADD_OVF_EN
        .cout(cout8), .ovf(ovf8)
`else
        .cout(cout8)
`endif
    );

    serial_add_seq #(.WIDTH(32)) dut32 (
        .clk(clk), .rst(rst), .start(start & (sel_r == 1)),
        .a_in(a_in), .b_in(b_in), .cin(cin),
        .busy(busy32), .done(done32), .sum(sum32),
`ifdef SERIAL_ADD_OVF_EN
        .cout(cout32), .ovf(ovf32)
`else
        .cout(cout32)
`endif
    );

`ifndef SERIAL_ADD_OVF_EN
    assign ovf8  = 1'b0;
    assign ovf32 = 1'b0;
`endif

    assign busy_o = (sel_r == 1) ? busy32 : busy8;
    assign done_o = (sel_r == 1) ? done32 : done8;
    assign cout_o = (sel_r == 1) ? cout32 : cout8;
    assign ovf_o  = (sel_r == 1) ? ovf32  : ovf8;
    assign sum_o  = (sel_r == 1) ? sum32  : {24'd0, sum8};

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Runs one operation; start cycle is cycle 0, returns in the cycle after done
    // (or after a bounded wait). Optional ignored starts at cycles j1/j2, reset at cycle rst_at.
    task automatic do_op(input int sel, input logic [31:0] a, input logic [31:0] b, input logic c,
                         input int j1, input int j2, input int rst_at, input string tag);
        int          w;
        int          k;
        int          done_cyc;
        int          busy_cnt;
        int          ndone;
        bit          fin;
        logic [31:0] s;
        logic        co, ov, pr_busy;
        logic [31:0] pr_sum;
        logic [32:0] full;
        logic [31:0] mask, e_sum;
        logic        e_co, e_ov;

        w        = (sel == 1) ? 32 : 8;
        mask     = (sel == 1) ? 32'hFFFF_FFFF : 32'h0000_00FF;
        done_cyc = -1;
        busy_cnt = 0;
        ndone    = 0;
        fin      = 0;
        s        = '0;
        co       = 1'b0;
        ov       = 1'b0;
        pr_busy  = 1'b1;
        pr_sum   = '1;

        sel_r = sel;
        a_in  = a;
        b_in  = b;
        cin   = c;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        a_in  = $urandom;
        b_in  = $urandom;
        cin   = 1'($urandom);
        k     = 1;
        while (!fin && k <= w + 4) begin
            if (busy_o) busy_cnt++;
            if (done_o) begin
                ndone++;
                if (done_cyc < 0) begin
                    done_cyc = k;
                    s  = sum_o;
                    co = cout_o;
                    ov = ovf_o;
                end
            end
            if (rst_at >= 0 && k == rst_at + 1) begin
                pr_busy = busy_o;
                pr_sum  = sum_o;
                rst     = 1'b0;
            end
            if (done_cyc >= 0 && k == done_cyc + 1) begin
                fin = 1;
            end else begin
                if (k == j1 || k == j2) begin
                    start = 1'b1;
                    a_in  = $urandom;
                    b_in  = $urandom;
                    cin   = 1'($urandom);
                end
                if (k == rst_at) rst = 1'b1;
                @(negedge clk);
                start = 1'b0;
                k++;
            end
        end

        if (rst_at >= 0) begin
            check({tag, "_rst_busy"}, 64'(pr_busy), 64'd0);
            check({tag, "_rst_sum"}, 64'(pr_sum), 64'd0);
            check({tag, "_rst_ndone"}, 64'(ndone), 64'd0);
            check({tag, "_rst_busycnt"}, 64'(busy_cnt), 64'(rst_at));
        end else begin
            full  = {1'b0, a & mask} + {1'b0, b & mask} + {32'd0, c};
            e_sum = full[31:0] & mask;
            e_co  = full[w];
            e_ov  = (a[w-1] == b[w-1]) && (e_sum[w-1] != a[w-1]);
            check({tag, "_done_cyc"}, 64'(done_cyc), 64'(w + 1));
            check({tag, "_busy_cnt"}, 64'(busy_cnt), 64'(w + 1));
            check({tag, "_ndone"}, 64'(ndone), 64'd1);
            check({tag, "_sum"}, 64'(s), 64'(e_sum));
            check({tag, "_cout"}, 64'(co), 64'(e_co));
            check({tag, "_sum_hold"}, 64'(sum_o), 64'(e_sum));
`ifdef SERIAL_ADD_OVF_EN
            check({tag, "_ovf"}, 64'(ov), 64'(e_ov));
`else
            if (ov !== 1'b0 || e_ov === 1'bx) check({tag, "_ovf_tied"}, 64'(ov), 64'd0);
`endif
        end
    endtask

    initial begin
        int j1, j2;
        rst   = 1'b1;
        start = 1'b0;
        a_in  = '0;
        b_in  = '0;
        cin   = 1'b0;
        sel_r = 0;
        repeat (3) @(negedge clk);
        rst = 1'b0;

        check("reset_busy8", 64'(busy8), 64'd0);
        check("reset_done8", 64'(done8), 64'd0);
        check("reset_sum8", 64'(sum8), 64'd0);
        check("reset_cout8", 64'(cout8), 64'd0);
        check("reset_busy32", 64'(busy32), 64'd0);
        check("reset_sum32", 64'(sum32), 64'd0);
`ifdef SERIAL_ADD_OVF_EN
        check("reset_ovf8", 64'(ovf8), 64'd0);
`endif

        do_op(0, 32'h5A, 32'h3C, 1'b0, -1, -1, -1, "d_5a_3c");
        do_op(0, 32'hFF, 32'h01, 1'b0, -1, -1, -1, "d_ff_01");
        do_op(0, 32'hFF, 32'h00, 1'b1, -1, -1, -1, "d_ff_00_c1");
        do_op(0, 32'h7F, 32'h01, 1'b0, -1, -1, -1, "d_7f_01");
        do_op(0, 32'h80, 32'h80, 1'b0, -1, -1, -1, "d_80_80");
        do_op(0, 32'h5A, 32'h3C, 1'b1, 3, 9, -1, "d_ignored_start");
        do_op(0, 32'hC3, 32'h11, 1'b0, -1, -1, -1, "d_back_to_back");
        do_op(0, 32'hAB, 32'hCD, 1'b1, -1, -1, 4, "d_mid_reset");
        do_op(0, 32'h12, 32'h34, 1'b1, -1, -1, -1, "d_after_reset");
        do_op(1, 32'hFFFF_FFFF, 32'h0000_0001, 1'b0, -1, -1, -1, "d32_wrap");
        do_op(1, 32'h7FFF_FFFF, 32'h0000_0000, 1'b1, -1, -1, -1, "d32_ovf");

        for (int i = 0; i < 1000; i++) begin
            j1 = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 9)) : -1;
            j2 = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 9)) : -1;
            do_op(0, $urandom, $urandom, 1'($urandom), j1, j2, -1, "rnd8");
        end
        for (int i = 0; i < 1000; i++) begin
            j1 = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 33)) : -1;
            do_op(1, $urandom, $urandom, 1'($urandom), j1, -1, -1, "rnd32");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
